shift_register_8bit: RTL and testbench
======================================

// Module: shift_register_8bit
// PURPOSE
//  8-bit parallel-load / serial-in right-shift register (74165-style) and the datapath core of
//  the SPI sender (parallel load, serial out on bit 0) and receiver (serial in on bit 7, parallel read).
//  Shifts LSB-first: bit 0 leaves first, the serial input enters at the MSB.
//  All 8 register bits are visible in parallel at all times.
// PARAMETERS
//  WIDTH  8  register width in bits; all behaviour below is written for WIDTH=8, MSB = WIDTH-1
// PORTS
//  CLK         in   1      shift clock, rising-edge; parents gate it to stop shifting
//  CLR         in   1      asynchronous, active-low reset; 0 clears the register
//  P_DATA_IN   in   WIDTH  parallel load data; used only while SH_LD=0, may be X/Z otherwise
//  S_DATA_IN   in   1      serial input, enters at bit WIDTH-1
//  SH_LD       in   1      1 = shift on CLK rising edge; 0 = parallel load (asynchronous, level)
//  P_DATA_OUT  out  WIDTH  register contents; bit 0 is the serial output bit
// BEHAVIOUR
//  - One clock (CLK); reset CLR is asynchronous and active-low. No other state.
//  - Priority, highest first: CLR=0 > SH_LD=0 > CLK rising edge with SH_LD=1.
//  - CLR=0: Q = 8'h00 immediately, independent of CLK; held while CLR=0. P_DATA_OUT reset value 8'h00.
//  - SH_LD=0 (CLR=1): asynchronous transparent load; Q follows P_DATA_IN combinationally
//    (per-bit preset/clear); CLK edges ignored. On SH_LD 0->1 Q retains the last loaded value.
//  - SH_LD=1 (CLR=1), CLK rising edge: Q <= {S_DATA_IN, Q[7:1]}. Latency 1 edge.
//    Bit 0 is shifted out (discarded internally); the parent samples it from P_DATA_OUT[0].
//  - No CLK edge and SH_LD=1: Q holds. Gated/stopped CLK holds Q indefinitely.
//  - After 8 shifts from a load of D with S_DATA_IN=0: Q=8'h00; bits left P_DATA_OUT[0] as D[0]..D[7].
//  - Receiving: serial bits b0..b7 shifted in on 8 edges give Q = {b7,...,b0} (first bit at bit 0).
//  - CLR released (0->1) with SH_LD=0: Q immediately follows P_DATA_IN.
//  - CLR asserted mid-shift: clears at once; the next shift starts from 8'h00.
//  - CLK edge coincident with SH_LD 1->0: the load value wins; any shift is overwritten.
//  - X/Z on P_DATA_IN while SH_LD=1 has no effect on Q.
//  - P_DATA_OUT is driven directly from the register; never tri-stated.
//  - Asynchronous load requires a preset/clear flop per bit, or an equivalent latch/flop mux;
//    a synthesizable model uses set/reset flops. Simulation must show the load with no CLK activity.
// TESTING
//  1 Reset: CLR=0 with Q=8'hFF -> P_DATA_OUT=8'h00 immediately, no CLK edge needed.
//  2 Async load: CLR=1, SH_LD=0, P_DATA_IN=8'hA5, CLK held low -> P_DATA_OUT=8'hA5.
//    Change P_DATA_IN to 8'h3C -> follows to 8'h3C.
//  3 Shift out: load 8'hA5, then SH_LD=1, S_DATA_IN=0, 8 CLK edges -> P_DATA_OUT[0]
//    reads 1,0,1,0,0,1,0,1 before edges 1..8; final Q=8'h00.
//  4 Shift in: from 8'h00, SH_LD=1, serial 1,1,0,1,0,0,1,0 on 8 edges -> Q=8'h4B; P_DATA_IN=Z has no effect.
//  5 Hold: SH_LD=1 with no CLK edges for 100 ns -> Q unchanged.
//  6 Priority: CLR=0 and SH_LD=0, P_DATA_IN=8'hFF -> Q=8'h00. Release CLR -> Q=8'hFF.
//    Reset mid-shift after 3 edges -> Q=8'h00.

Source files
------------

// File: rtl/shift_register_8bit.sv
// 8-bit parallel-load / serial-in right-shift register (74165-style).
// Built from one set/clear flop per bit so that the parallel load acts without any clock edge.
module shift_register_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] P_DATA_IN,
  input  logic             S_DATA_IN,
  input  logic             SH_LD,
  output logic [WIDTH-1:0] P_DATA_OUT
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] load_set_n_s;
  logic [WIDTH-1:0] load_clr_n_s;

  assign shift_d = {S_DATA_IN, q_q[WIDTH-1:1]};

  // Set is also gated by CLR so that releasing CLR during a load re-triggers the 1-bits.
  assign load_set_n_s = ~({WIDTH{CLR & ~SH_LD}} & P_DATA_IN);
  assign load_clr_n_s = ~({WIDTH{~SH_LD}} & ~P_DATA_IN);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic bit_q;

    // Per-bit flop: CLR clear, then asynchronous load (set/clear), then shift on CLK.
    always_ff @(posedge CLK or negedge CLR or negedge load_set_n_s[i] or negedge load_clr_n_s[i]) begin
      if (!CLR) begin
        bit_q <= 1'b0;
      end else if (!load_set_n_s[i]) begin
        bit_q <= 1'b1;
      end else if (!load_clr_n_s[i]) begin
        bit_q <= 1'b0;
      end else begin
        bit_q <= shift_d[i];
      end
    end

    assign q_q[i] = bit_q;
  end

  assign P_DATA_OUT = q_q;

endmodule

// File: tb/tb_shift_register_8bit.sv
// Directed self-checking bench for shift_register_8bit: reset, async load, shift out/in,
// hold, priority and a clock edge coincident with the start of a load.
module tb_shift_register_8bit;

  logic       CLK;
  logic       CLR;
  logic [7:0] P_DATA_IN;
  logic       S_DATA_IN;
  logic       SH_LD;
  logic [7:0] P_DATA_OUT;

  int checks;
  int errors;

  shift_register_8bit #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .P_DATA_IN (P_DATA_IN),
    .S_DATA_IN (S_DATA_IN),
    .SH_LD     (SH_LD),
    .P_DATA_OUT(P_DATA_OUT)
  );

  // One full clock period: rising edge, high phase, falling edge, low phase.
  task automatic tick();
    CLK = 1'b1;
    #5;
    CLK = 1'b0;
    #5;
  endtask

  task automatic test_reset();
    if (P_DATA_OUT !== 8'h00) begin
      $display("FAIL reset_initial got %h exp %h", P_DATA_OUT, 8'h00);
      errors++;
    end
    checks++;
    CLR = 1'b1; SH_LD = 1'b0; P_DATA_IN = 8'hFF;
    #2;
    if (P_DATA_OUT !== 8'hFF) begin
      $display("FAIL reset_preload got %h exp %h", P_DATA_OUT, 8'hFF);
      errors++;
    end
    checks++;
    SH_LD = 1'b1;
    CLR = 1'b0;
    #1;
    if (P_DATA_OUT !== 8'h00) begin
      $display("FAIL reset_async_clear got %h exp %h", P_DATA_OUT, 8'h00);
      errors++;
    end
    checks++;
    CLR = 1'b1;
    #1;
  endtask

  task automatic test_async_load();
    SH_LD = 1'b0; P_DATA_IN = 8'hA5;
    #1;
    if (P_DATA_OUT !== 8'hA5) begin
      $display("FAIL load_a5 got %h exp %h", P_DATA_OUT, 8'hA5);
      errors++;
    end
    checks++;
    P_DATA_IN = 8'h3C;
    #1;
    if (P_DATA_OUT !== 8'h3C) begin
      $display("FAIL load_follow_3c got %h exp %h", P_DATA_OUT, 8'h3C);
      errors++;
    end
    checks++;
    SH_LD = 1'b1;
    #1;
    P_DATA_IN = 8'h00;
    #1;
    if (P_DATA_OUT !== 8'h3C) begin
      $display("FAIL load_retain got %h exp %h", P_DATA_OUT, 8'h3C);
      errors++;
    end
    checks++;
  endtask

  task automatic test_shift_out();
    logic [7:0] exp_bits;
    exp_bits = 8'b1010_0101;
    SH_LD = 1'b0; P_DATA_IN = 8'hA5;
    #1;
    SH_LD = 1'b1; S_DATA_IN = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (P_DATA_OUT[0] !== exp_bits[i]) begin
        $display("FAIL shift_out_bit%0d got %b exp %b", i, P_DATA_OUT[0], exp_bits[i]);
        errors++;
      end
      checks++;
      tick();
    end
    if (P_DATA_OUT !== 8'h00) begin
      $display("FAIL shift_out_final got %h exp %h", P_DATA_OUT, 8'h00);
      errors++;
    end
    checks++;
  endtask

  task automatic test_shift_in();
    logic [7:0] serial;
    serial = 8'b0100_1011;  // b0 first: 1,1,0,1,0,0,1,0
    P_DATA_IN = 8'bzzzz_zzzz;
    SH_LD = 1'b1;
    for (int i = 0; i < 8; i++) begin
      S_DATA_IN = serial[i];
      tick();
      if (i == 2 && P_DATA_OUT !== 8'h60) begin
        $display("FAIL shift_in_mid got %h exp %h", P_DATA_OUT, 8'h60);
        errors++;
      end
      if (i == 2) checks++;
    end
    if (P_DATA_OUT !== 8'h4B) begin
      $display("FAIL shift_in_final got %h exp %h", P_DATA_OUT, 8'h4B);
      errors++;
    end
    checks++;
  endtask

  task automatic test_hold();
    S_DATA_IN = 1'b1;
    P_DATA_IN = 8'hFF;
    #100;
    if (P_DATA_OUT !== 8'h4B) begin
      $display("FAIL hold got %h exp %h", P_DATA_OUT, 8'h4B);
      errors++;
    end
    checks++;
  endtask

  task automatic test_priority();
    CLR = 1'b0; SH_LD = 1'b0; P_DATA_IN = 8'hFF;
    #1;
    if (P_DATA_OUT !== 8'h00) begin
      $display("FAIL prio_clr_over_load got %h exp %h", P_DATA_OUT, 8'h00);
      errors++;
    end
    checks++;
    CLR = 1'b1;
    #1;
    if (P_DATA_OUT !== 8'hFF) begin
      $display("FAIL prio_release_load got %h exp %h", P_DATA_OUT, 8'hFF);
      errors++;
    end
    checks++;
    SH_LD = 1'b1; S_DATA_IN = 1'b0;
    #1;
    tick(); tick(); tick();
    if (P_DATA_OUT !== 8'h1F) begin
      $display("FAIL prio_three_shifts got %h exp %h", P_DATA_OUT, 8'h1F);
      errors++;
    end
    checks++;
    CLR = 1'b0;
    #1;
    if (P_DATA_OUT !== 8'h00) begin
      $display("FAIL prio_clr_mid_shift got %h exp %h", P_DATA_OUT, 8'h00);
      errors++;
    end
    checks++;
    CLR = 1'b1; S_DATA_IN = 1'b1;
    #1;
    tick();
    if (P_DATA_OUT !== 8'h80) begin
      $display("FAIL prio_shift_after_clr got %h exp %h", P_DATA_OUT, 8'h80);
      errors++;
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    SH_LD = 1'b0; P_DATA_IN = 8'h0F;
    #1;
    SH_LD = 1'b1; S_DATA_IN = 1'b1; P_DATA_IN = 8'hC3;
    #4;
    CLK = 1'b1;
    SH_LD = 1'b0;
    #1;
    if (P_DATA_OUT !== 8'hC3) begin
      $display("FAIL edge_vs_load got %h exp %h", P_DATA_OUT, 8'hC3);
      errors++;
    end
    checks++;
    #4;
    CLK = 1'b0;
    #5;
    SH_LD = 1'b1; S_DATA_IN = 1'b0; P_DATA_IN = 8'bxxxx_xxxx;
    #1;
    if (P_DATA_OUT !== 8'hC3) begin
      $display("FAIL x_input_ignored got %h exp %h", P_DATA_OUT, 8'hC3);
      errors++;
    end
    checks++;
    tick();
    if (P_DATA_OUT !== 8'h61) begin
      $display("FAIL shift_after_edge_load got %h exp %h", P_DATA_OUT, 8'h61);
      errors++;
    end
    checks++;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    CLK       = 1'b0;
    CLR       = 1'b0;
    SH_LD     = 1'b1;
    S_DATA_IN = 1'b0;
    P_DATA_IN = 8'h00;
    #3;
    test_reset();
    test_async_load();
    test_shift_out();
    test_shift_in();
    test_hold();
    test_priority();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
